// File: rtl/smc_stream_if.sv
// Beat-in / result-out bundle of the streaming MOSFET calculator.
interface smc_stream_if #(
    parameter int DW = 3,
    parameter int VW = 3 * DW + 2
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] w;
    logic [DW-1:0] v_gs;
    logic [DW-1:0] v_ds;
    logic [1:0]    mode;
    logic          out_valid;
    logic [VW-1:0] out_n;

    modport master (
        output in_valid, w, v_gs, v_ds, mode,
        input  in_ready, out_valid, out_n
    );

    modport slave (
        input  in_valid, w, v_gs, v_ds, mode,
        output in_ready, out_valid, out_n
    );
endinterface

// File: rtl/smc_stream.sv
// Streaming MOSFET calculator: collects N_CH devices, keeps them sorted on arrival,
// and pulses the floor-average of the K largest or K smallest per-device values.
module smc_stream #(
    parameter int N_CH = 6,
    parameter int K    = 3,
    parameter int DW   = 3,
    parameter int VW   = 3 * DW + 2
) (
    input  logic        clk,
    input  logic        rst,
    smc_stream_if.slave bus
);
    localparam int CW = $clog2(N_CH + 1);
    localparam int SW = VW + $clog2(K);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_SUM     = 2'd2,
        ST_OUT     = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    mode_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [VW-1:0] out_n_q;
    logic [VW-1:0] sort_q [N_CH];

    logic          acc_s;
    logic          first_s;
    logic          cur_s;
    logic [CW-1:0] cnt_d;
    logic [VW-1:0] val_s;
    logic [VW-1:0] sort_d [N_CH];
    logic [SW-1:0] sum_s;

    // Drain current (cur_v=1) or transconductance of one device, all divisions floor.
    function automatic logic [VW-1:0] dev_value(
        input logic [DW-1:0] w_v,
        input logic [DW-1:0] vgs_v,
        input logic [DW-1:0] vds_v,
        input logic          cur_v
    );
        logic [VW-1:0] wx;
        logic [VW-1:0] gx;
        logic [VW-1:0] dx;
        logic [VW-1:0] ov;
        logic [VW-1:0] res;
        wx = VW'(w_v);
        gx = VW'(vgs_v);
        dx = VW'(vds_v);
        ov = gx - VW'(1);
        if (gx <= VW'(1)) begin
            res = '0;
        end else if (dx < ov) begin
            if (cur_v) begin
                res = (wx * (VW'(2) * ov * dx - dx * dx)) / VW'(3);
            end else begin
                res = (VW'(2) * wx * dx) / VW'(3);
            end
        end else begin
            if (cur_v) begin
                res = (wx * ov * ov) / VW'(3);
            end else begin
                res = (VW'(2) * wx * ov) / VW'(3);
            end
        end
        return res;
    endfunction

    // Beat acceptance and the value of the beat on the bus.
    always_comb begin
        acc_s   = bus.in_valid && in_ready_q;
        first_s = (state_q == ST_IDLE);
        cur_s   = first_s ? bus.mode[0] : mode_q[0];
        cnt_d   = first_s ? CW'(1) : cnt_q + CW'(1);
        val_s   = dev_value(bus.w, bus.v_gs, bus.v_ds, cur_s);
    end

    // Descending insertion; a new value lands after existing equal entries. Unused
    // slots hold zero, so dropping the tail entry never loses a collected value.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sort_d[i] = sort_q[i];
        end
        if (first_s) begin
            sort_d[0] = val_s;
        end else if (sort_q[0] >= val_s) begin
            sort_d[0] = sort_q[0];
        end else begin
            sort_d[0] = val_s;
        end
        for (int i = 1; i < N_CH; i++) begin
            if (first_s) begin
                sort_d[i] = '0;
            end else if (sort_q[i] >= val_s) begin
                sort_d[i] = sort_q[i];
            end else if (sort_q[i-1] >= val_s) begin
                sort_d[i] = val_s;
            end else begin
                sort_d[i] = sort_q[i-1];
            end
        end
    end

    // Sum of the head (largest) or tail (smallest) K entries.
    always_comb begin
        sum_s = '0;
        for (int i = 0; i < K; i++) begin
            if (mode_q[1]) begin
                sum_s = sum_s + SW'(sort_q[i]);
            end else begin
                sum_s = sum_s + SW'(sort_q[N_CH-K+i]);
            end
        end
    end

    // Group FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mode_q      <= 2'b00;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_n_q     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                sort_q[i] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    out_valid_q <= 1'b0;
                    out_n_q     <= '0;
                    if (acc_s) begin
                        sort_q <= sort_d;
                        cnt_q  <= cnt_d;
                        if (first_s) begin
                            mode_q <= bus.mode;
                        end
                        if (cnt_d == CW'(N_CH)) begin
                            state_q    <= ST_SUM;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_COLLECT;
                        end
                    end
                end
                ST_SUM: begin
                    out_valid_q <= 1'b1;
                    out_n_q     <= VW'(sum_s / SW'(K));
                    state_q     <= ST_OUT;
                end
                ST_OUT: begin
                    out_valid_q <= 1'b0;
                    out_n_q     <= '0;
                    in_ready_q  <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    out_valid_q <= 1'b0;
                    out_n_q     <= '0;
                    in_ready_q  <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_n     = out_n_q;
endmodule

// File: tb/tb_smc_stream.sv
// Scoreboard bench for smc_stream: directed groups push expected results and
// result cycles; an independent monitor compares every presented output.
module tb_smc_stream;
    localparam int N_CH = 6;
    localparam int K    = 3;
    localparam int DW   = 3;
    localparam int VW   = 11;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    exp_t e;

    logic [DW-1:0] gw  [N_CH];
    logic [DW-1:0] ggs [N_CH];
    logic [DW-1:0] gds [N_CH];

    smc_stream_if #(.DW(DW), .VW(VW)) bus ();

    smc_stream #(.N_CH(N_CH), .K(K), .DW(DW), .VW(VW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-reset cycle either a scoreboard pop or an idle-output check.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (bus.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: out_n=%0d at cyc %0d, required no pulse", bus.out_n, cyc);
                end else begin
                    e = q.pop_front();
                    if (bus.out_n !== VW'(e.val) || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result: out_n=%0d at cyc %0d, required %0d at cyc %0d",
                                 bus.out_n, cyc, e.val, e.cyc);
                    end
                end
            end else if (bus.out_valid !== 1'b0 || bus.out_n !== '0) begin
                errors++;
                $display("FAIL idle_out: out_valid=%b out_n=%0d at cyc %0d, required 0/0",
                         bus.out_valid, bus.out_n, cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask

    task automatic set_vec(input int i, input int wv, input int gsv, input int dsv);
        gw[i]  = DW'(wv);
        ggs[i] = DW'(gsv);
        gds[i] = DW'(dsv);
    endtask

    // Present beat i and hold it until accepted; acc returns the accepting edge index.
    task automatic put_beat(input int i, input logic [1:0] m, output int acc);
        logic rdy;
        int   waits;
        bus.w        = gw[i];
        bus.v_gs     = ggs[i];
        bus.v_ds     = gds[i];
        bus.mode     = m;
        bus.in_valid = 1'b1;
        waits = 0;
        forever begin
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waits++;
            if (waits > 50) begin
                checks++;
                errors++;
                $display("FAIL beat_wait: in_ready=0 for %0d cycles, required 1", waits);
                break;
            end
        end
        acc = cyc;
    endtask

    task automatic send_group(input logic [1:0] m, input logic tog, input int gapmax,
                              input int expv, output int first, output int last);
        int acc;
        int g;
        first = 0;
        for (int i = 0; i < N_CH; i++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            if (g > 0) begin
                bus.in_valid = 1'b0;
                repeat (g) begin
                    @(posedge clk);
                    #1;
                end
            end
            put_beat(i, (tog && i > 0) ? ~m : m, acc);
            if (i == 0) first = acc;
        end
        bus.in_valid = 1'b0;
        q.push_back('{expv, acc + 1});
        last = acc;
    endtask

    task automatic load_ramp(input logic rev);
        for (int i = 0; i < N_CH; i++) set_vec(i, 3, rev ? 6 - i : i + 1, 7);
    endtask

    task automatic load_triode();
        for (int i = 0; i < N_CH; i++) set_vec(i, 3, (i == 2) ? 0 : 7, 2);
    endtask

    task automatic load_max();
        for (int i = 0; i < N_CH; i++) set_vec(i, 7, 7, 7);
    endtask

    initial begin
        int first;
        int last;
        int last_a;
        int acc;
        bus.in_valid = 1'b0;
        bus.w        = '0;
        bus.v_gs     = '0;
        bus.v_ds     = '0;
        bus.mode     = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_n", 32'(bus.out_n), 32'd0);
        rst = 1'b0;

        load_ramp(1'b0);
        send_group(2'b10, 1'b0, 0, 8, first, last);
        send_group(2'b11, 1'b0, 0, 16, first, last);
        send_group(2'b01, 1'b0, 0, 1, first, last);

        load_triode();
        send_group(2'b11, 1'b0, 0, 20, first, last);
        send_group(2'b00, 1'b0, 0, 2, first, last);

        load_max();
        send_group(2'b01, 1'b0, 0, 84, first, last);

        load_ramp(1'b1);
        send_group(2'b10, 1'b0, 3, 8, first, last);
        send_group(2'b01, 1'b0, 2, 1, first, last);

        load_ramp(1'b0);
        send_group(2'b11, 1'b1, 0, 16, first, last);

        // Back-pressure: hold the next group's first beat through SUM and OUT.
        load_max();
        send_group(2'b01, 1'b0, 0, 84, first, last_a);
        load_triode();
        bus.w        = gw[0];
        bus.v_gs     = ggs[0];
        bus.v_ds     = gds[0];
        bus.mode     = 2'b11;
        bus.in_valid = 1'b1;
        check("bp_ready_sum", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("bp_ready_out", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        send_group(2'b11, 1'b0, 0, 20, first, last);
        check("bp_next_accept_edge", 32'(first - last_a), 32'd3);

        // Reset after the third beat of a group drops it entirely.
        load_max();
        for (int i = 0; i < 3; i++) put_beat(i, 2'b01, acc);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_n", 32'(bus.out_n), 32'd0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        load_ramp(1'b0);
        send_group(2'b10, 1'b0, 0, 8, first, last);

        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
